// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and the shared transmitter valid/ready port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
) ();
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_data, tx_valid
   );

   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of one UART transmitter, with a
// single holding register and a stall timeout that reclaims abandoned grants.
module uart_tx_arbiter #(
   parameter int  NUM_REQ = 4,
   parameter int  TIMEOUT = 1024,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               resetn,
   uart_tx_arbiter_if.slave   bus,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     grant_id,
   output logic               busy,
   output logic               timeout_pulse
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int PW = IDW + 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

   state_t               r_state, w_state_nxt;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IDW-1:0]       r_grant_id;
   logic [IDW-1:0]       r_rr_ptr;
   logic                 r_tx_valid;
   logic [7:0]           r_tx_data;
   logic                 r_hold_last;
   logic [CW-1:0]        r_tmo_cnt;
   logic                 r_timeout_pulse;

   logic                 w_room, w_req_hs, w_tx_hs, w_sel_last, w_count, w_tmo_hit;
   logic [7:0]           w_sel_data;
   logic [NUM_REQ-1:0]   w_req_ready;
   logic [2*NUM_REQ-1:0] w_dbl;
   logic [PW-1:0]        w_off, w_sum;
   logic [IDW-1:0]       w_pick_id, w_ptr_adv;

   assign w_room      = !r_tx_valid || bus.tx_ready;
   assign w_req_ready = (r_state == S_GRANT && w_room) ? r_grant : '0;
   assign w_req_hs    = |(bus.req_valid & w_req_ready);
   assign w_tx_hs     = r_tx_valid && bus.tx_ready;
   assign w_sel_data  = bus.req_data[{r_grant_id, 3'b000} +: 8];
   assign w_sel_last  = bus.req_last[r_grant_id];
   assign w_count     = (r_state == S_GRANT) && !w_req_hs && !r_tx_valid;
   assign w_tmo_hit   = (TIMEOUT > 0) && w_count && (r_tmo_cnt == CW'(TIMEOUT - 1));
   assign w_ptr_adv   = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + IDW'(1);

   // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit wins.
   assign w_dbl = {bus.req_valid, bus.req_valid} >> r_rr_ptr;

   always_comb begin
      w_off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_dbl[k]) w_off = PW'(k);
      end
      w_sum     = {1'b0, r_rr_ptr} + w_off;
      w_pick_id = (w_sum >= PW'(NUM_REQ)) ? IDW'(w_sum - PW'(NUM_REQ)) : IDW'(w_sum);
   end

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (|bus.req_valid) w_state_nxt = S_GRANT;
         S_GRANT: begin
            if (w_req_hs && w_sel_last) w_state_nxt = S_DRAIN;
            else if (w_tmo_hit)         w_state_nxt = S_IDLE;
         end
         S_DRAIN: if (w_tx_hs && r_hold_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_grant         <= '0;
         r_grant_id      <= '0;
         r_rr_ptr        <= '0;
         r_tx_valid      <= 1'b0;
         r_tx_data       <= '0;
         r_hold_last     <= 1'b0;
         r_tmo_cnt       <= '0;
         r_timeout_pulse <= 1'b0;
      end else begin
         r_timeout_pulse <= w_tmo_hit;

         if (r_state == S_IDLE && |bus.req_valid) begin
            r_grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_id;
            r_grant_id <= w_pick_id;
         end else if ((r_state == S_DRAIN && w_tx_hs) || w_tmo_hit) begin
            r_grant  <= '0;
            r_rr_ptr <= w_ptr_adv;
         end

         // A load and an unload on the same edge keep the register full.
         if (w_req_hs) begin
            r_tx_data   <= w_sel_data;
            r_tx_valid  <= 1'b1;
            r_hold_last <= w_sel_last;
         end else if (w_tx_hs) begin
            r_tx_valid  <= 1'b0;
            r_hold_last <= 1'b0;
         end

         if ((TIMEOUT == 0) || r_state != S_GRANT || w_req_hs || w_tmo_hit)
            r_tmo_cnt <= '0;
         else if (w_count)
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.tx_data   = r_tx_data;
   assign bus.tx_valid  = r_tx_valid;
   assign grant         = r_grant;
   assign grant_id      = r_grant_id;
   assign busy          = (r_state != S_IDLE);
   assign timeout_pulse = r_timeout_pulse;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the DUT and
// a scoreboard of {owner id, byte} in expected wire order checks the tx stream.
module tb_uart_tx_arbiter;
   localparam int NR  = 4;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          resetn;
   logic [NR-1:0] grant;
   logic [1:0]    grant_id;
   logic          busy;
   logic          timeout_pulse;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .bus           (bus),
      .grant         (grant),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [8:0]  rq [NR][$];
   logic [31:0] sb [$];
   int          start_at [NR];
   logic        bp_mode = 1'b0;
   int          eng_start, leak_cnt, hs_cnt, first_hs, last_hs;
   int          g_rise, g_fall, v_rise, p_cnt, p_cyc;
   logic [NR-1:0] g_val, p_grant;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input int r, input int base, input int n, input bit with_last);
      for (int i = 0; i < n; i++)
         rq[r].push_back({(with_last && i == n - 1), 8'(base + i)});
   endtask

   task automatic exp_pkt(input int r, input int base, input int n);
      for (int i = 0; i < n; i++)
         sb.push_back(32'((r << 8) | ((base + i) & 255)));
   endtask

   task automatic clear_marks();
      leak_cnt = 0; hs_cnt = 0; first_hs = -1; last_hs = -1;
      g_rise = -1; g_fall = -1; v_rise = -1; p_cnt = 0; p_cyc = -1;
      for (int r = 0; r < NR; r++) start_at[r] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      bus.req_valid = '0;
      bus.req_last  = '0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // Presents each requester's queue head and pops it on a handshake edge.
   task automatic run_engine(input int maxcyc);
      int n;
      logic [NR-1:0] hs;
      bit done, empty;
      n = 0; done = 1'b0; eng_start = -1;
      while (!done && n < maxcyc) begin
         @(negedge clk);
         if (eng_start < 0) eng_start = cyc;
         bus.tx_ready = bp_mode ? (cyc % 10 == 9) : 1'b1;
         empty = 1'b1;
         for (int r = 0; r < NR; r++) begin
            if (rq[r].size() > 0) empty = 1'b0;
            if (rq[r].size() > 0 && cyc >= start_at[r]) begin
               bus.req_valid[r]        = 1'b1;
               bus.req_data[8*r +: 8]  = rq[r][0][7:0];
               bus.req_last[r]         = rq[r][0][8];
            end else begin
               bus.req_valid[r] = 1'b0;
               bus.req_last[r]  = 1'b0;
            end
         end
         #1;
         hs = bus.req_valid & bus.req_ready;
         if ((bus.req_ready & ~grant) != '0) leak_cnt++;
         if (empty && !busy && !bus.tx_valid) done = 1'b1;
         else begin
            @(posedge clk);
            for (int r = 0; r < NR; r++) if (hs[r]) void'(rq[r].pop_front());
            n++;
         end
      end
      chk("engine_done", 32'(done), 32'd1);
      #2;
   endtask

   // Output monitor, sampling mid-cycle after the drivers have settled.
   logic [NR-1:0] prev_grant = '0;
   logic          prev_hold  = 1'b0;
   logic          prev_txv   = 1'b0;
   logic [7:0]    prev_data  = '0;
   logic [31:0]   exp_e;

   always begin
      @(negedge clk);
      #2;
      if (bus.tx_valid && bus.tx_ready) begin
         hs_cnt++;
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
         if (sb.size() == 0) chk("tx_unexpected", 32'({grant_id, bus.tx_data}), 32'hFFFF_FFFF);
         else begin
            exp_e = sb.pop_front();
            chk("tx_byte", 32'({grant_id, bus.tx_data}), exp_e);
         end
      end
      if (prev_hold && bus.tx_valid) chk("tx_stable", 32'(bus.tx_data), 32'(prev_data));
      if (bus.tx_valid && !bus.tx_ready) chk("ready_while_full", 32'(bus.req_ready), 32'd0);
      if (grant != '0 && prev_grant == '0 && g_rise < 0) begin g_rise = cyc; g_val = grant; end
      if (grant == '0 && prev_grant != '0) g_fall = cyc;
      if (bus.tx_valid && !prev_txv && v_rise < 0) v_rise = cyc;
      if (timeout_pulse) begin p_cnt++; p_cyc = cyc; p_grant = grant; end
      prev_grant = grant;
      prev_hold  = bus.tx_valid && !bus.tx_ready;
      prev_txv   = bus.tx_valid;
      prev_data  = bus.tx_data;
   end

   initial begin
      resetn        = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.tx_ready  = 1'b0;
      clear_marks();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_grant",     32'(grant),         32'd0);
      chk("rst_grant_id",  32'(grant_id),      32'd0);
      chk("rst_tx_valid",  32'(bus.tx_valid),  32'd0);
      chk("rst_tx_data",   32'(bus.tx_data),   32'd0);
      chk("rst_busy",      32'(busy),          32'd0);
      chk("rst_tmo_pulse", 32'(timeout_pulse), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      resetn = 1'b1;

      // Single packet from requester 1, minimum latency.
      clear_marks();
      add_pkt(1, 'h41, 3, 1'b1);
      exp_pkt(1, 'h41, 3);
      run_engine(100);
      chk("single_grant_val",  32'(g_val),    32'b0010);
      chk("single_grant_lat",  32'(g_rise),   32'(eng_start + 1));
      chk("single_txv_lat",    32'(v_rise),   32'(eng_start + 2));
      chk("single_release",    32'(g_fall),   32'(last_hs + 1));
      chk("single_sb_empty",   32'(sb.size()), 32'd0);

      // rr_ptr is now 2: requester 2 beats requester 1.
      clear_marks();
      add_pkt(1, 'h11, 2, 1'b1);
      add_pkt(2, 'h21, 2, 1'b1);
      exp_pkt(2, 'h21, 2);
      exp_pkt(1, 'h11, 2);
      run_engine(100);
      chk("ptr2_sb_empty", 32'(sb.size()), 32'd0);

      // Round-robin from reset, then wrap from rr_ptr=3 back to requester 0.
      do_reset();
      clear_marks();
      add_pkt(0, 'h01, 2, 1'b1);
      add_pkt(2, 'h21, 2, 1'b1);
      exp_pkt(0, 'h01, 2);
      exp_pkt(2, 'h21, 2);
      run_engine(100);
      add_pkt(0, 'h05, 2, 1'b1);
      add_pkt(2, 'h25, 2, 1'b1);
      exp_pkt(0, 'h05, 2);
      exp_pkt(2, 'h25, 2);
      run_engine(100);
      chk("rr_sb_empty", 32'(sb.size()), 32'd0);

      // Requester 3 arrives mid-packet of requester 1 and must wait.
      clear_marks();
      start_at[3] = cyc + 3;
      add_pkt(1, 'h31, 4, 1'b1);
      add_pkt(3, 'h71, 2, 1'b1);
      exp_pkt(1, 'h31, 4);
      exp_pkt(3, 'h71, 2);
      run_engine(100);
      chk("nointl_ready_leak", 32'(leak_cnt),  32'd0);
      chk("nointl_sb_empty",   32'(sb.size()), 32'd0);

      // Backpressure: transmitter ready one cycle in ten.
      clear_marks();
      bp_mode = 1'b1;
      add_pkt(0, 'hA0, 4, 1'b1);
      exp_pkt(0, 'hA0, 4);
      run_engine(200);
      bp_mode = 1'b0;
      chk("bp_hs_count", 32'(hs_cnt),    32'd4);
      chk("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Abandoned packet: TMO full idle cycles follow the handshake, then the pulse.
      do_reset();
      clear_marks();
      add_pkt(2, 'h55, 1, 1'b0);
      add_pkt(3, 'h66, 1, 1'b1);
      exp_pkt(2, 'h55, 1);
      exp_pkt(3, 'h66, 1);
      run_engine(300);
      chk("tmo_pulse_count", 32'(p_cnt),     32'd1);
      chk("tmo_pulse_cycle", 32'(p_cyc),     32'(first_hs + 1 + TMO));
      chk("tmo_grant_clear", 32'(p_grant),   32'd0);
      chk("tmo_sb_empty",    32'(sb.size()), 32'd0);

      // Reset in the middle of a held byte.
      clear_marks();
      add_pkt(1, 'h81, 1, 1'b1);
      exp_pkt(1, 'h81, 1);
      run_engine(100);
      @(negedge clk);
      bus.tx_ready          = 1'b0;
      bus.req_valid[2]      = 1'b1;
      bus.req_data[23:16]   = 8'h99;
      bus.req_last[2]       = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.tx_valid) break;
      end
      chk("abort_txv_before", 32'(bus.tx_valid), 32'd1);
      bus.req_valid[2] = 1'b0;
      resetn = 1'b0;
      @(negedge clk);
      #1;
      chk("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("abort_grant",    32'(grant),        32'd0);
      chk("abort_busy",     32'(busy),         32'd0);
      resetn = 1'b1;
      clear_marks();
      add_pkt(1, 'h91, 1, 1'b1);
      add_pkt(3, 'hB1, 1, 1'b1);
      exp_pkt(1, 'h91, 1);
      exp_pkt(3, 'hB1, 1);
      run_engine(100);
      chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one fractional-divider UART transmitter between NUM_REQ byte-stream requesters, for example a debug console, a loader ack path and a status reporter. Arbitration is round-robin at packet granularity. A requester keeps the grant from its first byte through the byte flagged last, so packets never interleave on the wire. A single holding register sits between the granted requester and the transmitter's valid/ready port. A stall timeout reclaims the grant from a requester that abandons a packet.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
TIMEOUT, 1024, idle cycles allowed inside a granted packet before the grant is revoked; 0 disables the timeout
IDW, $clog2(NUM_REQ), width of grant_id (derived, not overridable)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  marks the final byte of a packet; qualified by req_valid
req_ready  out  NUM_REQ  per-requester accept strobe
tx_data  out  8  byte to the transmitter
tx_valid  out  1  byte valid to the transmitter
tx_ready  in  1  transmitter idle/accept; connects to the tx ready output
grant  out  NUM_REQ  one-hot current owner; all zero when unowned
grant_id  out  IDW  binary index of the owner; holds its last value when unowned
busy  out  1  high in GRANT or DRAIN
timeout_pulse  out  1  one-cycle strobe when a grant is revoked by timeout

Behaviour:
- Reset values: state=IDLE, grant=0, grant_id=0, rr_ptr=0, tx_valid=0, tx_data=0, hold_last=0, timeout counter=0, timeout_pulse=0, busy=0.
- Reset mid-packet aborts everything immediately. The transmitter shares resetn, so any partially sent frame is also cut.
- Handshakes: a transfer occurs on any edge where valid&&ready.
  - tx_valid is held, with tx_data stable, until the tx_ready handshake.
  - Requesters must hold req_data/req_last stable while req_valid&&!req_ready.
- req_ready[i] is combinational: (state==GRANT) && grant[i] && (!tx_valid || tx_ready). Non-granted bits are always 0.
- Holding register: a requester handshake loads tx_data<=byte, tx_valid<=1, hold_last<=req_last. A simultaneous tx handshake and new load is legal and gives back-to-back bytes.
- State IDLE:
  - If any req_valid is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - Next cycle: grant one-hot, grant_id = that index, state=GRANT.
  - Minimum latency: req_valid at cycle 0, req_ready at cycle 1, tx_valid at cycle 2.
- State GRANT: accepts bytes as above. On acceptance of a byte with req_last=1, go to DRAIN; no further req_ready for this packet.
- State DRAIN: wait for the tx handshake of the held byte, then state=IDLE, grant=0, rr_ptr=grant_id+1 (wrap NUM_REQ-1 to 0).
  - One IDLE cycle always separates packets.
  - A last requester cannot regain the grant while another requester is valid.
- Timeout (TIMEOUT>0):
  - The counter increments in GRANT on each cycle with no requester handshake and tx_valid==0.
  - It clears on any requester handshake and on entry to GRANT.
  - When it reaches TIMEOUT: timeout_pulse=1 for one cycle, state=IDLE, grant=0, rr_ptr advances as on normal completion.
  - A pending held byte is impossible at that point, because the counter only counts while tx_valid==0.
  - Counter width: $clog2(TIMEOUT+1).
- A requester that drops req_valid after being selected simply gets the grant and falls to the timeout. No retraction logic.
- busy = (state != IDLE).
- Transmitter compatibility: tx ready falls the cycle after acceptance. No second byte is presented on a stale ready, since tx_valid deasserts or reloads only at the handshake edge.

Test Plan:
- Single packet: req 1 sends 0x41,0x42,0x43 (last on 0x43), tx_ready=1 -> grant=0010 at cycle 1, tx bytes 41,42,43 in order, grant=0 one cycle after the 0x43 tx handshake, rr_ptr=2.
- Round-robin: req 0 and req 2 valid simultaneously from reset, 2-byte packets -> req 0 served first, then req 2. Next with req 0 and req 2 both valid again, rr_ptr=3 -> req 0 wins via wrap.
- No interleave: req 3 valid mid-packet of req 1 -> tx stream shows all of req 1's bytes contiguously, then req 3's. req_ready[3]=0 throughout req 1's grant.
- Backpressure: tx_ready high 1 cycle in every 10 during a 4-byte packet -> each byte sent exactly once, tx_data stable while waiting, req_ready low while holding is full and tx_ready=0.
- Timeout: TIMEOUT=16, req 2 sends 0x55 without last, then drops valid -> 0x55 transmitted, timeout_pulse exactly 16 idle cycles after tx handshake, grant=0, req 3 granted next.
- Reset mid-packet: resetn low 1 cycle while tx_valid=1 -> next cycle tx_valid=0, grant=0, busy=0; a fresh request is granted normally afterward from rr_ptr=0.
